// File: rtl/ee354_detour_pkg.sv
// ----------------------------------------------------------------------------
// ee354_detour_pkg
// Shared definitions for the detour-sign lamp bus monitor.
//   - lamp pattern constants for the bus {GLL, GL, GR, GRR}
//   - one-hot FSM state encoding for the monitor
//   - sweep direction constants
//   - decoded-lamp record produced by ee354_detour_lamp_decode
// ----------------------------------------------------------------------------
package ee354_detour_pkg;

    // Lamp patterns, bit order {GLL, GL, GR, GRR}
    localparam logic [3:0] PAT_IDLE = 4'b0000;
    localparam logic [3:0] PAT_R1   = 4'b1000;
    localparam logic [3:0] PAT_R12  = 4'b1100;
    localparam logic [3:0] PAT_R123 = 4'b1110;
    localparam logic [3:0] PAT_L1   = 4'b0001;
    localparam logic [3:0] PAT_L12  = 4'b0011;
    localparam logic [3:0] PAT_L123 = 4'b0111;

    // Sweep direction
    localparam logic DIR_L = 1'b1;
    localparam logic DIR_R = 1'b0;

    // Monitor FSM, one-hot
    typedef enum logic [4:0] {
        ST_RESYNC = 5'b00001,
        ST_IDLE   = 5'b00010,
        ST_S1     = 5'b00100,
        ST_S12    = 5'b01000,
        ST_S123   = 5'b10000
    } state_t;

    // Decoded lamp pattern. step is 1..3 for sweep steps, 0 for idle/illegal.
    typedef struct packed {
        logic       legal;
        logic       is_idle;
        logic       dir;
        logic [1:0] step;
    } lamp_dec_t;

endpackage

// File: rtl/ee354_detour_lamp_decode.sv
// ----------------------------------------------------------------------------
// ee354_detour_lamp_decode
// Combinational decode of one lamp pattern into legality, idle flag, sweep
// direction and step number.
//   pattern : in  4  lamp vector {GLL, GL, GR, GRR}
//   dec     : out    {legal, is_idle, dir, step[1:0]}
// ----------------------------------------------------------------------------
module ee354_detour_lamp_decode
    import ee354_detour_pkg::*;
(
    input  logic [3:0] pattern,
    output lamp_dec_t  dec
);

    always_comb begin
        dec = '0;
        case (pattern)
            PAT_IDLE: begin
                dec.legal   = 1'b1;
                dec.is_idle = 1'b1;
            end
            PAT_R1: begin
                dec.legal = 1'b1;
                dec.dir   = DIR_R;
                dec.step  = 2'd1;
            end
            PAT_R12: begin
                dec.legal = 1'b1;
                dec.dir   = DIR_R;
                dec.step  = 2'd2;
            end
            PAT_R123: begin
                dec.legal = 1'b1;
                dec.dir   = DIR_R;
                dec.step  = 2'd3;
            end
            PAT_L1: begin
                dec.legal = 1'b1;
                dec.dir   = DIR_L;
                dec.step  = 2'd1;
            end
            PAT_L12: begin
                dec.legal = 1'b1;
                dec.dir   = DIR_L;
                dec.step  = 2'd2;
            end
            PAT_L123: begin
                dec.legal = 1'b1;
                dec.dir   = DIR_L;
                dec.step  = 2'd3;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/ee354_detour_monitor.sv
// ----------------------------------------------------------------------------
// ee354_detour_monitor
// Receive-side checker for the detour-sign lamp bus. Registers the lamps,
// tracks sweep progress, counts completed sweeps and raises sticky flags for
// illegal patterns, out-of-order steps and stalled sequences.
//
// Ports:
//   Clk         : in   system clock
//   reset       : in   asynchronous active-high reset
//   GLL/GL/GR/GRR : in lamp bus, far left .. far right
//   clr_err     : in   synchronous clear of the sticky error flags
//   dir_valid   : out  a direction has been decoded since the last resync
//   dir_L_Rbar  : out  1 = left sweep, 0 = right sweep
//   sweep_done  : out  one-cycle pulse per completed sweep
//   sweep_cnt   : out  saturating completed-sweep count
//   err_illegal : out  sticky, pattern outside the decode table
//   err_seq     : out  sticky, legal pattern out of order
//   err_stall   : out  sticky, non-idle pattern held STALL_MAX samples
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RESYNC | after reset/error; wait for all lamps off, no checking
// ST_IDLE   | lamps off; next sweep may start in either direction
// ST_S1     | first lamp of the latched direction seen
// ST_S12    | first two lamps seen
// ST_S123   | all three lamps seen; all-off completes the sweep
// ----------------------------------------------------------------------------
module ee354_detour_monitor
    import ee354_detour_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 16
)
(
    input  logic             Clk,
    input  logic             reset,
    input  logic             GLL,
    input  logic             GL,
    input  logic             GR,
    input  logic             GRR,
    input  logic             clr_err,
    output logic             dir_valid,
    output logic             dir_L_Rbar,
    output logic             sweep_done,
    output logic [CNT_W-1:0] sweep_cnt,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_stall
);

    localparam int STALL_W = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;
    // The counter holds the number of repeats after the first sample of a
    // step, so the STALL_MAX-th identical sample arrives with it at STALL_MAX-2.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 2);

    logic [3:0]         lamp_q;
    lamp_dec_t          dec;
    state_t             state, state_nxt;
    logic               dir, dir_nxt;
    logic [STALL_W-1:0] stall_cnt, stall_nxt;
    logic               valid_nxt, lr_nxt, done_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               set_ill, set_seq, set_stall;
    logic [1:0]         cur_step;
    logic               is_repeat, is_next;

    ee354_detour_lamp_decode u_decode (
        .pattern (lamp_q),
        .dec     (dec)
    );

    always_comb begin
        case (state)
            ST_S1:   cur_step = 2'd1;
            ST_S12:  cur_step = 2'd2;
            ST_S123: cur_step = 2'd3;
            default: cur_step = 2'd0;
        endcase
    end

    assign is_repeat = dec.legal && !dec.is_idle && (dec.dir == dir)
                       && (dec.step == cur_step);
    assign is_next   = dec.legal && !dec.is_idle && (dec.dir == dir)
                       && (dec.step == cur_step + 2'd1);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            lamp_q      <= PAT_IDLE;
            state       <= ST_RESYNC;
            dir         <= DIR_R;
            stall_cnt   <= '0;
            dir_valid   <= 1'b0;
            dir_L_Rbar  <= 1'b0;
            sweep_done  <= 1'b0;
            sweep_cnt   <= '0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_stall   <= 1'b0;
        end else begin
            lamp_q      <= {GLL, GL, GR, GRR};
            state       <= state_nxt;
            dir         <= dir_nxt;
            stall_cnt   <= stall_nxt;
            dir_valid   <= valid_nxt;
            dir_L_Rbar  <= lr_nxt;
            sweep_done  <= done_nxt;
            sweep_cnt   <= cnt_nxt;
            // A new error in the same cycle as clr_err keeps the flag set.
            err_illegal <= set_ill   | (err_illegal & ~clr_err);
            err_seq     <= set_seq   | (err_seq     & ~clr_err);
            err_stall   <= set_stall | (err_stall   & ~clr_err);
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        stall_nxt = stall_cnt;
        valid_nxt = dir_valid;
        lr_nxt    = dir_L_Rbar;
        done_nxt  = 1'b0;
        cnt_nxt   = sweep_cnt;
        set_ill   = 1'b0;
        set_seq   = 1'b0;
        set_stall = 1'b0;

        case (state)
            ST_RESYNC: begin
                valid_nxt = 1'b0;
                stall_nxt = '0;
                if (dec.is_idle) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                stall_nxt = '0;
                if (!dec.legal) begin
                    set_ill = 1'b1;
                end else if (dec.is_idle) begin
                    state_nxt = ST_IDLE;
                end else if (dec.step == 2'd1) begin
                    state_nxt = ST_S1;
                    dir_nxt   = dec.dir;
                    valid_nxt = 1'b1;
                    lr_nxt    = dec.dir;
                end else begin
                    set_seq = 1'b1;
                end
            end

            ST_S1, ST_S12, ST_S123: begin
                if (!dec.legal) begin
                    set_ill = 1'b1;
                end else if (is_repeat) begin
                    if (stall_cnt == STALL_LAST) begin
                        set_stall = 1'b1;
                    end else begin
                        stall_nxt = stall_cnt + STALL_W'(1);
                    end
                end else if ((state == ST_S123) && dec.is_idle) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    stall_nxt = '0;
                    if (sweep_cnt != {CNT_W{1'b1}}) begin
                        cnt_nxt = sweep_cnt + CNT_W'(1);
                    end
                end else if ((state != ST_S123) && is_next) begin
                    state_nxt = (state == ST_S1) ? ST_S12 : ST_S123;
                    stall_nxt = '0;
                end else begin
                    set_seq = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_RESYNC;
                valid_nxt = 1'b0;
                stall_nxt = '0;
            end
        endcase

        if (set_ill || set_seq || set_stall) begin
            state_nxt = ST_RESYNC;
            valid_nxt = 1'b0;
            stall_nxt = '0;
        end
    end

endmodule

// File: tb/tb_ee354_detour_monitor.sv
// ----------------------------------------------------------------------------
// tb_ee354_detour_monitor
// Drives lamp sequences into two monitors (default counter width and a 2-bit
// counter) and compares every cycle against a sequence-position reference
// model through an expectation queue, plus fixed expected values at the
// milestones of each scenario.
// ----------------------------------------------------------------------------
module tb_ee354_detour_monitor;

    localparam int STALL_MAX = 16;

    logic       Clk = 1'b0;
    logic       reset;
    logic       GLL, GL, GR, GRR;
    logic       clr_err;

    logic       dir_valid, dir_L_Rbar, sweep_done;
    logic [7:0] sweep_cnt;
    logic       err_illegal, err_seq, err_stall;

    logic       s_dir_valid, s_dir_L_Rbar, s_sweep_done;
    logic [1:0] s_sweep_cnt;
    logic       s_err_illegal, s_err_seq, s_err_stall;

    always #10 Clk = ~Clk;

    ee354_detour_monitor #(.CNT_W(8), .STALL_MAX(STALL_MAX)) dut (
        .Clk (Clk), .reset (reset),
        .GLL (GLL), .GL (GL), .GR (GR), .GRR (GRR),
        .clr_err (clr_err),
        .dir_valid (dir_valid), .dir_L_Rbar (dir_L_Rbar),
        .sweep_done (sweep_done), .sweep_cnt (sweep_cnt),
        .err_illegal (err_illegal), .err_seq (err_seq), .err_stall (err_stall)
    );

    ee354_detour_monitor #(.CNT_W(2), .STALL_MAX(STALL_MAX)) dut_sat (
        .Clk (Clk), .reset (reset),
        .GLL (GLL), .GL (GL), .GR (GR), .GRR (GRR),
        .clr_err (clr_err),
        .dir_valid (s_dir_valid), .dir_L_Rbar (s_dir_L_Rbar),
        .sweep_done (s_sweep_done), .sweep_cnt (s_sweep_cnt),
        .err_illegal (s_err_illegal), .err_seq (s_err_seq), .err_stall (s_err_stall)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic valid, lr, done, ill, seq, stall;
        int   cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] prev_pat;

    bit   m_sync;
    int   m_pos, m_run, m_cnt;
    logic m_dir, m_valid, m_lr, m_done, m_ill, m_seq, m_stall;

    function automatic logic [3:0] seq_pat(input logic d, input int k);
        case (k)
            1:       return d ? 4'b0001 : 4'b1000;
            2:       return d ? 4'b0011 : 4'b1100;
            3:       return d ? 4'b0111 : 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_sync = 0; m_pos = 0; m_run = 0; m_cnt = 0;
        m_dir = 0; m_valid = 0; m_lr = 0; m_done = 0;
        m_ill = 0; m_seq = 0; m_stall = 0;
    endtask

    // One clock edge as seen by the monitor: p is the registered lamp value.
    task automatic model_step(input logic [3:0] p, input logic clr);
        logic e_ill, e_seq, e_stall;
        bit   legal;
        e_ill = 0; e_seq = 0; e_stall = 0;
        legal = (p == 4'b0000);
        for (int k = 1; k <= 3; k++)
            if (p == seq_pat(1'b0, k) || p == seq_pat(1'b1, k)) legal = 1;
        m_done = 0;
        if (!m_sync) begin
            if (p == 4'b0000) begin m_sync = 1; m_pos = 0; end
        end else if (!legal) begin
            e_ill = 1;
        end else if (m_pos == 0) begin
            if (p == seq_pat(1'b0, 1) || p == seq_pat(1'b1, 1)) begin
                m_dir = (p == seq_pat(1'b1, 1));
                m_pos = 1; m_run = 1; m_valid = 1; m_lr = m_dir;
            end else if (p != 4'b0000) begin
                e_seq = 1;
            end
        end else if (p == seq_pat(m_dir, m_pos)) begin
            m_run++;
            if (m_run == STALL_MAX) e_stall = 1;
        end else if (m_pos == 3 && p == 4'b0000) begin
            m_done = 1; m_pos = 0; m_cnt++;
        end else if (m_pos < 3 && p == seq_pat(m_dir, m_pos + 1)) begin
            m_pos++; m_run = 1;
        end else begin
            e_seq = 1;
        end
        if (e_ill || e_seq || e_stall) begin
            m_sync = 0; m_pos = 0; m_valid = 0;
        end
        m_ill   = e_ill   | (m_ill   & ~clr);
        m_seq   = e_seq   | (m_seq   & ~clr);
        m_stall = e_stall | (m_stall & ~clr);
    endtask

    // Called at a falling edge: compare the oldest expectation, drive the
    // next lamps, then queue the result of the edge that is coming up.
    task automatic cyc(input logic [3:0] lamps, input logic clr);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dir_valid",   dir_valid,   e.valid);
            chk("dir_L_Rbar",  dir_L_Rbar,  e.lr);
            chk("sweep_done",  sweep_done,  e.done);
            chk("sweep_cnt",   sweep_cnt,   (e.cnt > 255) ? 255 : e.cnt);
            chk("err_illegal", err_illegal, e.ill);
            chk("err_seq",     err_seq,     e.seq);
            chk("err_stall",   err_stall,   e.stall);
            chk("sat_done",    s_sweep_done, e.done);
            chk("sat_cnt",     s_sweep_cnt,  (e.cnt > 3) ? 3 : e.cnt);
        end
        {GLL, GL, GR, GRR} = lamps;
        clr_err = clr;
        model_step(prev_pat, clr);
        e.valid = m_valid; e.lr = m_lr; e.done = m_done; e.cnt = m_cnt;
        e.ill = m_ill; e.seq = m_seq; e.stall = m_stall;
        exp_q.push_back(e);
        prev_pat = lamps;
        @(negedge Clk);
    endtask

    task automatic sweep(input logic d);
        for (int k = 1; k <= 3; k++) cyc(seq_pat(d, k), 1'b0);
        cyc(4'b0000, 1'b0);
    endtask

    task automatic flush();
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, dir_valid, 1'b0);
        chk({tag, "_lr"},    dir_L_Rbar, 1'b0);
        chk({tag, "_done"},  sweep_done, 1'b0);
        chk({tag, "_cnt"},   sweep_cnt, 8'd0);
        chk({tag, "_ill"},   err_illegal, 1'b0);
        chk({tag, "_seq"},   err_seq, 1'b0);
        chk({tag, "_stall"}, err_stall, 1'b0);
        chk({tag, "_scnt"},  s_sweep_cnt, 2'd0);
    endtask

    initial begin
        reset = 1'b1;
        {GLL, GL, GR, GRR} = 4'b0000;
        clr_err = 1'b0;
        model_reset();
        prev_pat = 4'b0000;
        #5;
        chk_all_zero("reset");
        #17 reset = 1'b0;
        // rising edge at 30 ns sees lamp_q = 0000 before the first falling edge
        model_step(4'b0000, 1'b0);
        @(negedge Clk);
        flush();
        chk_all_zero("idle");

        // single right sweep
        sweep(1'b0);
        flush();
        chk("r_cnt",   sweep_cnt, 8'd1);
        chk("r_valid", dir_valid, 1'b1);
        chk("r_lr",    dir_L_Rbar, 1'b0);

        // alternating right/left sweeps
        for (int i = 0; i < 3; i++) begin
            sweep(1'b0);
            sweep(1'b1);
        end
        flush();
        chk("alt_cnt",  sweep_cnt, 8'd7);
        chk("alt_lr",   dir_L_Rbar, 1'b1);
        chk("alt_errs", {err_illegal, err_seq, err_stall}, 3'b000);

        // skipped step
        cyc(4'b1000, 1'b0);
        cyc(4'b1110, 1'b0);
        cyc(4'b0000, 1'b0);
        chk("skip_seq",   err_seq, 1'b1);
        chk("skip_valid", dir_valid, 1'b0);
        sweep(1'b1);
        flush();
        chk("rec_cnt", sweep_cnt, 8'd8);
        chk("rec_seq", err_seq, 1'b1);
        chk("rec_lr",  dir_L_Rbar, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        chk("clr_seq", err_seq, 1'b0);

        // illegal pattern from idle
        cyc(4'b0101, 1'b0);
        cyc(4'b0000, 1'b0);
        chk("ill_flag", err_illegal, 1'b1);
        cyc(4'b0000, 1'b0);

        // stall: 1100 held for STALL_MAX samples
        cyc(4'b1000, 1'b0);
        for (int i = 0; i < STALL_MAX; i++) cyc(4'b1100, 1'b0);
        flush();
        chk("stall_flag", err_stall, 1'b1);
        cyc(4'b0000, 1'b0);

        // clear coinciding with a new illegal event
        cyc(4'b0101, 1'b0);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        chk("setwin_ill",   err_illegal, 1'b1);
        chk("setwin_stall", err_stall, 1'b0);
        flush();

        // reset in the middle of a sweep (state S12)
        cyc(4'b1000, 1'b0);
        cyc(4'b1100, 1'b0);
        cyc(4'b1110, 1'b0);
        chk("pre_rst_valid", dir_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge Clk);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        prev_pat = 4'b0000;

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) sweep(1'b0);
        flush();
        chk("sat_main_cnt", sweep_cnt, 8'd5);
        chk("sat_cnt3",     s_sweep_cnt, 2'd3);
        chk("sat_errs",     {err_illegal, err_seq, err_stall}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
